// File: rtl/tick_timer.sv
// ============================================================================
//  Module   : tick_timer
//  Purpose  : Tick-enabled down-counting timer with one-shot/periodic modes,
//             pause/resume, an expiry pulse and a sticky interrupt flag.
//             Optional count capture port: define TICK_TIMER_CAPTURE_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic             irq
`ifdef TICK_TIMER_CAPTURE_EN
    ,
    input  logic             capture,
    output logic [WIDTH-1:0] capture_val
`endif
);

    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_reload_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_mode;
    logic             w_mode_nxt;
    logic             w_expired_nxt;
    logic             w_irq_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_reload <= C_ZERO;
            r_mode   <= 1'b0;
            count    <= C_ZERO;
            busy     <= 1'b0;
            expired  <= 1'b0;
            irq      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_reload <= w_reload_nxt;
            r_mode   <= w_mode_nxt;
            count    <= w_count_nxt;
            busy     <= (w_state_nxt == ST_RUN);
            expired  <= w_expired_nxt;
            irq      <= w_irq_nxt;
        end
    end

    // One command is honoured per cycle: load, then stop, then start/tick.
    always_comb begin
        w_state_nxt   = r_state;
        w_reload_nxt  = r_reload;
        w_mode_nxt    = r_mode;
        w_count_nxt   = count;
        w_expired_nxt = 1'b0;
        w_irq_nxt     = irq & ~irq_clr;

        if (load) begin
            w_count_nxt  = load_val;
            w_reload_nxt = load_val;
        end else if (stop) begin
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_PAUSE;
            end
        end else if (start && (r_state != ST_RUN)) begin
            if (count != C_ZERO) begin
                w_state_nxt = ST_RUN;
                w_mode_nxt  = periodic;
            end
        end else if ((r_state == ST_RUN) && tick) begin
            if (count > C_ONE) begin
                w_count_nxt = count - C_ONE;
            end else if (count == C_ONE) begin
                w_expired_nxt = 1'b1;
                w_irq_nxt     = 1'b1;
                if (r_mode) begin
                    // Reload directly so the period is exactly reload ticks.
                    w_count_nxt = r_reload;
                    if (r_reload == C_ZERO) begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_count_nxt = C_ZERO;
                    w_state_nxt = ST_IDLE;
                end
            end
        end
    end

`ifdef TICK_TIMER_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            capture_val <= C_ZERO;
        end else if (capture) begin
            capture_val <= count;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_tick_timer.sv
// ============================================================================
//  Module   : tb_tick_timer
//  Purpose  : Self-checking bench for tick_timer: directed vector table plus
//             randomized traffic against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tick_timer;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n, tick, load, start, stop, periodic, irq_clr, capture;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] count;
    logic             busy, expired, irq;
`ifdef TICK_TIMER_CAPTURE_EN
    logic [WIDTH-1:0] capture_val;
`endif

    always #5 clk = ~clk;

    tick_timer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .load       (load),
        .load_val   (load_val),
        .start      (start),
        .stop       (stop),
        .periodic   (periodic),
        .irq_clr    (irq_clr),
        .count      (count),
        .busy       (busy),
        .expired    (expired),
        .irq        (irq)
`ifdef TICK_TIMER_CAPTURE_EN
        ,
        .capture    (capture),
        .capture_val(capture_val)
`endif
    );

    typedef struct {
        bit       rst_n, load, start, stop, periodic, tick, irq_clr, capture;
        int       load_val;
        int       e_count;
        bit       e_busy, e_exp, e_irq;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t v(input bit rn, input bit ld, input int lv, input bit sa,
                               input bit sp, input bit per, input bit tk, input bit clr,
                               input int ec, input bit eb, input bit ee, input bit ei);
        vec_t r;
        r.rst_n = rn; r.load = ld; r.load_val = lv; r.start = sa; r.stop = sp;
        r.periodic = per; r.tick = tk; r.irq_clr = clr; r.capture = 1'b0;
        r.e_count = ec; r.e_busy = eb; r.e_exp = ee; r.e_irq = ei;
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
    task automatic drive(input vec_t x);
        @(negedge clk);
        rst_n = x.rst_n; load = x.load; load_val = WIDTH'(x.load_val);
        start = x.start; stop = x.stop; periodic = x.periodic;
        tick = x.tick; irq_clr = x.irq_clr; capture = x.capture;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: plain integers and a running/paused description.
    int m_count, m_reload, m_cap;
    bit m_running, m_paused, m_periodic, m_exp, m_irq;

    task automatic model_step(input vec_t x);
        if (!x.rst_n) begin
            m_count = 0; m_reload = 0; m_cap = 0;
            m_running = 0; m_paused = 0; m_periodic = 0; m_exp = 0; m_irq = 0;
        end else begin
            if (x.capture) m_cap = m_count;
            m_exp = 0;
            if (x.irq_clr) m_irq = 0;
            if (x.load) begin
                m_count = x.load_val; m_reload = x.load_val;
            end else if (x.stop) begin
                if (m_running) begin m_running = 0; m_paused = 1; end
            end else if (x.start && !m_running) begin
                if (m_count != 0) begin
                    m_running = 1; m_paused = 0; m_periodic = x.periodic;
                end
            end else if (m_running && x.tick && m_count > 0) begin
                m_count = m_count - 1;
                if (m_count == 0) begin
                    m_exp = 1; m_irq = 1;
                    if (m_periodic) m_count = m_reload;
                    if (m_count == 0) m_running = 0;
                end
            end
        end
    endtask

    vec_t tbl[$];

    initial begin
        vec_t x;
        rst_n = 0; tick = 0; load = 0; load_val = '0; start = 0; stop = 0;
        periodic = 0; irq_clr = 0; capture = 0;

        //            rn ld lv sa sp per tk clr  cnt busy exp irq
        // Reset held with commands active
        tbl.push_back(v(0, 1, 7, 1, 0, 0, 1, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 1, 7, 1, 0, 0, 1, 0,   0, 0, 0, 0));
        tbl.push_back(v(0, 1, 7, 1, 0, 0, 1, 0,   0, 0, 0, 0));
        // One-shot from 3
        tbl.push_back(v(1, 1, 3, 0, 0, 0, 0, 0,   3, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0,   3, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   2, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0));
        // Periodic with reload 2
        tbl.push_back(v(1, 1, 2, 0, 0, 0, 0, 0,   2, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 1, 0, 0,   2, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 1,   2, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   2, 1, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 1,   2, 1, 1, 1));
        // Pause / resume from 5
        tbl.push_back(v(1, 1, 5, 0, 0, 0, 0, 1,   5, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   4, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   3, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 0, 0,   3, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   3, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   3, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0,   3, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   2, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1));
        // Corners: start at zero, load over tick, stop over final tick, reset mid-run
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0,   0, 0, 0, 1));
        tbl.push_back(v(1, 1, 4, 0, 0, 0, 0, 0,   4, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0,   4, 1, 0, 1));
        tbl.push_back(v(1, 1, 9, 0, 0, 0, 1, 0,   9, 1, 0, 1));
        tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 0,   1, 1, 0, 1));
        tbl.push_back(v(1, 0, 0, 0, 1, 0, 1, 0,   1, 0, 0, 1));
        tbl.push_back(v(1, 0, 0, 1, 0, 0, 0, 0,   1, 1, 0, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i]);
            check($sformatf("vec%0d.count", i), int'(count), tbl[i].e_count);
            check($sformatf("vec%0d.busy", i), int'(busy), int'(tbl[i].e_busy));
            check($sformatf("vec%0d.expired", i), int'(expired), int'(tbl[i].e_exp));
            check($sformatf("vec%0d.irq", i), int'(irq), int'(tbl[i].e_irq));
        end

`ifdef TICK_TIMER_CAPTURE_EN
        // Capture samples the pre-tick count while the tick still applies.
        drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        check("cap.reset", int'(capture_val), 0);
        drive(v(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        drive(v(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        x = v(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        x.capture = 1'b1;
        drive(x);
        check("cap.value", int'(capture_val), 4);
        check("cap.count", int'(count), 3);
`endif

        // Randomized traffic against the model, starting from reset.
        x = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_step(x);
        drive(x);
        for (int n = 0; n < 3000; n++) begin
            x.rst_n    = ($urandom_range(0, 199) != 0);
            x.load     = ($urandom_range(0, 11) == 0);
            x.load_val = int'($urandom_range(0, 5));
            x.start    = ($urandom_range(0, 3) == 0);
            x.stop     = ($urandom_range(0, 11) == 0);
            x.periodic = 1'($urandom_range(0, 1));
            x.tick     = 1'($urandom_range(0, 1));
            x.irq_clr  = ($urandom_range(0, 9) == 0);
            x.capture  = ($urandom_range(0, 3) == 0);
            model_step(x);
            drive(x);
            check("rnd.count", int'(count), m_count);
            check("rnd.busy", int'(busy), int'(m_running));
            check("rnd.expired", int'(expired), int'(m_exp));
            check("rnd.irq", int'(irq), int'(m_irq));
`ifdef TICK_TIMER_CAPTURE_EN
            check("rnd.capture_val", int'(capture_val), m_cap);
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
